// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one read-write data-memory port between two requesters
// Ports:
//   clk, rst (async, active-low)
//   req_valid/ready/addr/wdata/we/lock{0,1} : request side, ready is a combinational grant
//   rsp_valid/data{0,1}, err{0,1}            : read return and misalignment pulse, one cycle after transfer
//   mem_en/addr/wdata/we, mem_rdata          : memory side, data returns one cycle after a read
// Round-robin between the ports; a locking port keeps the grant for up to MAX_LOCK
// consecutive grants while the other port waits, unbounded while the other port is idle.
module dmem_port_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid0,
    input  logic        req_valid1,
    output logic        req_ready0,
    output logic        req_ready1,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [3:0]  req_we0,
    input  logic [3:0]  req_we1,
    input  logic        req_lock0,
    input  logic        req_lock1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [31:0] rsp_data0,
    output logic [31:0] rsp_data1,
    output logic        err0,
    output logic        err1,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          port_q, port_d;
    logic [1:0]    err_q, err_d;
    logic          xfer, sel, aligned, lock_sel;
    logic [31:0]   addr_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            port_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = xfer ? sel : last_q;
        pend_d  = mem_en && mem_we == 4'b0000;
        port_d  = sel;
        err_d   = {req_ready1 && !aligned, req_ready0 && !aligned};
        case (state_q)
            ARB: if (xfer && lock_sel) begin
                state_d = sel ? HOLD1 : HOLD0;
                cnt_d   = CW'(1);
            end
            // In a hold state only the holder can transfer, so xfer identifies it.
            default: if (!xfer || !lock_sel) state_d = ARB;
                     else cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        endcase
    end

    always_comb begin
        // A holder that has used up its lock yields a dead cycle so ARB can hand over.
        req_ready0 = rst && req_valid0 && (state_q == ARB ? (!req_valid1 || last_q)
                     : state_q == HOLD0 && !(req_valid1 && cnt_q == CNT_MAX));
        req_ready1 = rst && req_valid1 && (state_q == ARB ? (!req_valid0 || !last_q)
                     : state_q == HOLD1 && !(req_valid0 && cnt_q == CNT_MAX));
        xfer       = req_ready0 || req_ready1;
        sel        = req_ready1;
        addr_sel   = sel ? req_addr1 : req_addr0;
        lock_sel   = sel ? req_lock1 : req_lock0;
        aligned    = addr_sel[1:0] == 2'b00;
        mem_en     = xfer && aligned;
        mem_addr   = mem_en ? addr_sel : '0;
        mem_wdata  = mem_en ? (sel ? req_wdata1 : req_wdata0) : '0;
        mem_we     = mem_en ? (sel ? req_we1 : req_we0) : '0;
        rsp_valid0 = pend_q && !port_q;
        rsp_valid1 = pend_q && port_q;
        rsp_data0  = rsp_valid0 ? mem_rdata : '0;
        rsp_data1  = rsp_valid1 ? mem_rdata : '0;
        err0       = err_q[0];
        err1       = err_q[1];
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a behavioural model
module tb_dmem_port_arbiter;
    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] wd [2];
    logic [3:0]  we [2];
    logic        lk [2];
    logic [31:0] mem_rdata = '0;
    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, err0, err1, mem_en;
    logic [31:0] rsp_data0, rsp_data1, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    int nvec = 0;
    int nbad = 0;

    // model state: who holds a lock (-1 none), how many grants in a row, who was granted last
    int holder = -1;
    int streak = 0;
    int lastg  = 1;
    bit pend   = 1'b0;
    int pport  = 0;
    bit perr0  = 1'b0;
    bit perr1  = 1'b0;
    int last_eg = -1;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(v[0]), .req_valid1(v[1]),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_addr0(a[0]), .req_addr1(a[1]),
        .req_wdata0(wd[0]), .req_wdata1(wd[1]),
        .req_we0(we[0]), .req_we1(we[1]),
        .req_lock0(lk[0]), .req_lock1(lk[1]),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .err0(err0), .err1(err1),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int eg, gi;
        bit en;
        logic [127:0] em, er;
        if (!rst) begin
            chk("reset_outputs", {req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1,
                                  err0, err1, mem_en, mem_addr, mem_wdata, mem_we}, '0);
            holder = -1; streak = 0; lastg = 1; pend = 0; perr0 = 0; perr1 = 0; last_eg = -1;
        end else begin
            eg = -1;
            if (holder < 0) begin
                if (v[0] && v[1]) eg = 1 - lastg;
                else if (v[0]) eg = 0;
                else if (v[1]) eg = 1;
            end else if (v[holder] && !(v[1-holder] && streak >= MAX_LOCK)) eg = holder;
            gi = eg < 0 ? 0 : eg;
            en = eg >= 0 && a[gi][1:0] == 2'b00;
            em = {eg == 0, eg == 1, en, en ? we[gi] : 4'h0, en ? a[gi] : 32'h0, en ? wd[gi] : 32'h0};
            er = {pend && pport == 0, pend && pport == 1,
                  (pend && pport == 0) ? mem_rdata : 32'h0, (pend && pport == 1) ? mem_rdata : 32'h0,
                  perr0, perr1};
            chk("mem_side", {req_ready0, req_ready1, mem_en, mem_we, mem_addr, mem_wdata}, em);
            chk("rsp_side", {rsp_valid0, rsp_valid1, rsp_data0, rsp_data1, err0, err1}, er);
            pend  = en && we[gi] == 4'h0;
            pport = gi;
            perr0 = eg == 0 && !en;
            perr1 = eg == 1 && !en;
            if (eg >= 0) begin
                if (lk[eg]) begin
                    streak = holder < 0 ? 1 : (streak < MAX_LOCK ? streak + 1 : streak);
                    holder = eg;
                end else holder = -1;
                lastg = eg;
            end else holder = -1;
            last_eg = eg;
        end
    end

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; a[p] = '0; wd[p] = '0; we[p] = '0; lk[p] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    int gseq[9] = '{0, 1, 1, 1, 1, 2, 0, 1, 1};

    initial begin
        idle();
        do_reset();
        @(negedge clk);
        chk("idle_out", {req_ready0, req_ready1, mem_en, mem_we, mem_addr, rsp_valid0, rsp_valid1, err0, err1}, '0);
        @(posedge clk); #1;
        v[0] = 1; a[0] = 32'h40; we[0] = 4'h0;
        @(negedge clk);
        chk("rd0_ready", req_ready0, 1);
        chk("rd0_en", mem_en, 1);
        chk("rd0_addr", mem_addr, 32'h40);
        @(posedge clk); #1;
        v[0] = 0; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd0_rsp", {rsp_valid0, rsp_data0, rsp_valid1}, {1'b1, 32'hDEADBEEF, 1'b0});
        @(posedge clk); #1;
        do_reset();
        v[0] = 1; a[0] = 32'h100; v[1] = 1; a[1] = 32'h200; we[1] = 4'hF; wd[1] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("contend_grant", {req_ready0, req_ready1}, (i % 2) ? 2'b01 : 2'b10);
            chk("contend_we", mem_we, (i % 2) ? 4'hF : 4'h0);
            @(posedge clk); #1;
        end
        idle();
        v[0] = 1; a[0] = 32'h42; we[0] = 4'h3;
        @(negedge clk);
        chk("mis_accept", {req_ready0, mem_en, mem_we}, {1'b1, 1'b0, 4'h0});
        @(posedge clk); #1;
        v[0] = 0;
        @(negedge clk);
        chk("mis_err", {err0, rsp_valid0}, 2'b10);
        @(posedge clk); #1;
        do_reset();
        v[0] = 1; a[0] = 32'h10; v[1] = 1; a[1] = 32'h20; lk[1] = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("lock_seq", req_ready0 ? 0 : (req_ready1 ? 1 : 2), gseq[i]);
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        v[1] = 1; a[1] = 32'h80;
        @(negedge clk);
        chk("rd1_ready", req_ready1, 1);
        @(posedge clk); #1;
        v[1] = 0;
        #1 chk("rd1_rsp", rsp_valid1, 1);
        #1 rst = 1'b0;
        #1 chk("async_drop", rsp_valid1, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_late_rsp", rsp_valid1, 0);
        end
        repeat (2000) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!v[p] || last_eg == p) begin
                    logic [31:0] r;
                    r = $urandom;
                    v[p]  = $urandom_range(3) != 0;
                    a[p]  = {r[31:2], ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00};
                    wd[p] = $urandom;
                    we[p] = $urandom_range(1) ? 4'h0 : 4'($urandom);
                    lk[p] = $urandom_range(1) == 1;
                end
            end
            mem_rdata = $urandom;
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single read-write data-memory port between two requesters: port 0 (processor datapath) and port 1 (loader/DMA engine).
- Grants one access per cycle. Arbitration is round-robin.
- A requester may hold a bounded lock for multi-word bursts.
- Read responses are routed back to the requester that issued them.
- Sits between the requesters and the memory's dmem port, which has word-aligned addresses, byte write-enables and read-first data returned one cycle after the access.

Parameters:
- MAX_LOCK, 4: maximum consecutive grants one locked requester may hold while the other port is waiting (minimum 1).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid0 / req_valid1  in  1  request present on port N.
- req_ready0 / req_ready1  out  1  port N granted this cycle (combinational).
- req_addr0 / req_addr1  in  32  byte address; bits [1:0] must be 00.
- req_wdata0 / req_wdata1  in  32  store data.
- req_we0 / req_we1  in  4  byte write enables; 0000 means a read.
- req_lock0 / req_lock1  in  1  keep the grant on the following cycle.
- rsp_valid0 / rsp_valid1  out  1  read data valid for port N.
- rsp_data0 / rsp_data1  out  32  read data.
- err0 / err1  out  1  one-cycle pulse: a misaligned request was accepted and dropped.
- mem_en  out  1  memory access this cycle.
- mem_addr  out  32  muxed address.
- mem_wdata  out  32  muxed store data.
- mem_we  out  4  muxed byte enables; forced to 0000 when mem_en=0.
- mem_rdata  in  32  memory read data, valid the cycle after a read.

Behaviour:
- Handshake:
  - Transfer on port N when req_validN && req_readyN.
  - At most one ready is high per cycle.
  - ready is never asserted without the matching valid.
  - Requesters must hold all request fields stable until the transfer.
- Memory drive: on a transfer with addr[1:0]==00:
  - mem_en=1;
  - mem_addr, mem_wdata and mem_we are taken from the granted port, in the same cycle.
- Misaligned transfer (addr[1:0]!=00):
  - The transfer is still accepted (ready=1).
  - mem_en=0 and mem_we=0000.
  - errN pulses in the next cycle.
  - No rsp_valid is generated.
- Response path:
  - An aligned read transfer sets the registered flags rsp_pend=1 and rsp_port=N.
  - In the next cycle rsp_validN=1 and rsp_dataN=mem_rdata.
  - The other port's rsp_valid stays 0; its rsp_data is 0.
  - Writes produce no response.
  - Back-to-back reads yield back-to-back responses; there is no throughput loss.
- State machine, states ARB, HOLD0, HOLD1:
  - ARB, one valid: grant it.
  - ARB, both valid: grant the port != last_grant.
  - ARB, neither valid: no grant.
  - ARB, on a transfer: last_grant <= N. If req_lockN=1, go to HOLDN with lock_cnt <= 1.
  - HOLDN: only port N may be granted, even if the other port is valid.
  - HOLDN, port N transfers with lock=1: lock_cnt++.
  - HOLDN, lock=0 on a transfer, or req_validN=0: return to ARB.
  - HOLDN, lock_cnt==MAX_LOCK while the other port is valid: return to ARB without granting N that cycle. The next ARB cycle grants the other port (last_grant==N).
  - HOLDN, other port idle: no limit; lock_cnt saturates at MAX_LOCK.
- Counter: lock_cnt is $clog2(MAX_LOCK+1) bits wide and saturates; it never wraps.
- Reset (rst=0, asynchronous), takes effect immediately and regardless of clk:
  - state=ARB, last_grant=1 (so port 0 wins the first contended cycle), lock_cnt=0, rsp_pend=0, err regs=0.
  - All outputs 0: ready, rsp_valid, rsp_data, err, mem_en, mem_addr, mem_wdata, mem_we.
- Reset mid-operation: a pending response is dropped. The memory side's read-first behaviour is not the arbiter's concern.
- Latency:
  - Grant is 0 cycles (combinational).
  - Read data arrives at the requester 1 cycle after the transfer.
  - err arrives 1 cycle after the transfer.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release, no valids -> all outputs 0, mem_en=0, no rsp_valid.
- Single read on port 0: addr=0x40, we=0000 -> same cycle ready0=1, mem_en=1, mem_addr=0x40. Next cycle, with mem_rdata=0xDEADBEEF -> rsp_valid0=1, rsp_data0=0xDEADBEEF, rsp_valid1=0.
- Contention, both ports valid continuously without lock, port 1 writing we=1111 -> grants alternate 0,1,0,1 starting with port 0. mem_we=1111 only on port-1 cycles.
- Lock limit, MAX_LOCK=4: port 1 valid with lock=1 for 8 cycles, port 0 valid throughout -> if port 0 holds the first grant, port 1 then gets 4 consecutive grants, then port 0 gets exactly one grant, then port 1 resumes. Port 0 never waits more than 5 cycles.
- Misaligned: port 0 sends addr=0x42, we=0011 -> ready0=1, mem_en=0, mem_we=0000. Next cycle err0=1 and rsp_valid0=0.
- Async reset mid-read: after a port-1 read transfer, drive rst=0 between clock edges -> rsp_valid1 drops immediately and no response appears after rst is released.
